mux_sel_sequencer: RTL and testbench

Parallel-in, serial-out sequencer that sits directly upstream of the team's 8:1 behavioural mux. It accepts an 8-bit word through a valid/ready handshake and holds it on the mux data inputs (I0..I7). It then steps the 3-bit select (S0,S1,S2) through all eight positions, one per accepted serial beat, so the mux output becomes a serial bitstream. It also instantiates the mux internally to provide a registered, self-contained serial output for downstream consumers.

---
 rtl/mux_sel_sequencer_pkg.sv | 13 +
 rtl/mux_sel_sequencer_mux_8x1.sv | 32 +++
 rtl/mux_sel_sequencer.sv | 110 +++++++++++
 tb/tb_mux_sel_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_sel_sequencer_pkg.sv
// rtl/mux_sel_sequencer_pkg.sv - shared state encoding and widths for the mux select sequencer
package mux_sel_sequencer_pkg;

    localparam int SEL_W  = 3;
    localparam int WORD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mux_sel_sequencer_mux_8x1.sv
// rtl/mux_sel_sequencer_mux_8x1.sv - 8:1 behavioural mux, output = I[{S0,S1,S2}]
module mux_8x1 (
    input  logic S0,
    input  logic S1,
    input  logic S2,
    input  logic I0,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic I4,
    input  logic I5,
    input  logic I6,
    input  logic I7,
    output logic Y
);

    always_comb begin
        Y = 1'b0;
        case ({S0, S1, S2})
            3'd0: Y = I0;
            3'd1: Y = I1;
            3'd2: Y = I2;
            3'd3: Y = I3;
            3'd4: Y = I4;
            3'd5: Y = I5;
            3'd6: Y = I6;
            3'd7: Y = I7;
            default: Y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - loads a parallel word and walks the 8:1 mux select to serialize it
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic [WORD_W-1:0] DATA_IN,
    input  logic              SER_READY,
    output logic              SER_VALID,
    output logic              SER_LAST,
    output logic              S0,
    output logic              S1,
    output logic              S2,
    output logic [WORD_W-1:0] D_OUT,
    output logic              SER_OUT,
    output logic              DONE,
    output logic              BUSY
);

    localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [SEL_W-1:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam bit               B2B_OK    = (GAP_CYCLES == 0);

    seq_state_t       state;
    logic [SEL_W-1:0] sel;
    logic [3:0]       gap_cnt;
    logic             load_fire;
    logic             beat_fire;

    assign SER_VALID = (state == SHIFT);
    assign BUSY      = (state != IDLE);
    assign SER_LAST  = SER_VALID && (sel == END_IDX);
    assign {S0, S1, S2} = sel;

    // Back-to-back reload is only possible when no gap is configured.
    assign LOAD_READY = (state == IDLE) || (B2B_OK && SER_LAST && SER_READY);
    assign load_fire  = LOAD_VALID && LOAD_READY;
    assign beat_fire  = SER_VALID && SER_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            sel     <= '0;
            D_OUT   <= '0;
            gap_cnt <= '0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_fire) begin
                        D_OUT <= DATA_IN;
                        sel   <= START_IDX;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat_fire) begin
                        if (sel == END_IDX) begin
                            DONE <= 1'b1;
                            if (load_fire) begin
                                D_OUT <= DATA_IN;
                                sel   <= START_IDX;
                            end else if (GAP_CYCLES > 0) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (MSB_FIRST) begin
                            sel <= sel - 3'd1;
                        end else begin
                            sel <= sel + 3'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mux_8x1 u_mux (
        .S0 (sel[2]),
        .S1 (sel[1]),
        .S2 (sel[0]),
        .I0 (D_OUT[0]),
        .I1 (D_OUT[1]),
        .I2 (D_OUT[2]),
        .I3 (D_OUT[3]),
        .I4 (D_OUT[4]),
        .I5 (D_OUT[5]),
        .I6 (D_OUT[6]),
        .I7 (D_OUT[7]),
        .Y  (SER_OUT)
    );

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - self-checking bench for mux_sel_sequencer (MSB/gap-0 and LSB/gap-3 instances)
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] data_in;
    logic       ser_ready;

    logic [1:0] load_ready, ser_valid, ser_last, s0, s1, s2, ser_out, done, busy;
    logic [7:0] d_out [2];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state, one slot per instance
    bit         msb_cfg [2] = '{1'b1, 1'b0};
    int         gap_cfg [2] = '{0, 3};
    bit         active  [2];
    int         beat    [2];
    int         gapleft [2];
    logic [7:0] word    [2];
    bit         done_m  [2];
    int         sel_m   [2];
    logic [7:0] rx0, rx1;

    always #5 clk = ~clk;

    mux_sel_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
        .CLK(clk), .RST(rst), .LOAD_VALID(load_valid), .LOAD_READY(load_ready[0]),
        .DATA_IN(data_in), .SER_READY(ser_ready), .SER_VALID(ser_valid[0]),
        .SER_LAST(ser_last[0]), .S0(s0[0]), .S1(s1[0]), .S2(s2[0]), .D_OUT(d_out[0]),
        .SER_OUT(ser_out[0]), .DONE(done[0]), .BUSY(busy[0])
    );

    mux_sel_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut1 (
        .CLK(clk), .RST(rst), .LOAD_VALID(load_valid), .LOAD_READY(load_ready[1]),
        .DATA_IN(data_in), .SER_READY(ser_ready), .SER_VALID(ser_valid[1]),
        .SER_LAST(ser_last[1]), .S0(s0[1]), .S1(s1[1]), .S2(s2[1]), .D_OUT(d_out[1]),
        .SER_OUT(ser_out[1]), .DONE(done[1]), .BUSY(busy[1])
    );

    task automatic chk(input string tag, input int m, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, m, obs, exp);
    endtask

    function automatic bit m_ready(input int m);
        return (!active[m] && gapleft[m] == 0) ||
               (gap_cfg[m] == 0 && active[m] && beat[m] == 7 && ser_ready);
    endfunction

    task automatic cycle(input bit check);
        bit rdy [2];
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            if (check) begin
                chk("load_ready", m, 8'(load_ready[m]), 8'(m_ready(m)));
                chk("ser_valid",  m, 8'(ser_valid[m]),  8'(active[m]));
                chk("ser_last",   m, 8'(ser_last[m]),   8'(active[m] && beat[m] == 7));
                chk("sel",        m, 8'({s0[m], s1[m], s2[m]}), 8'(sel_m[m]));
                chk("d_out",      m, d_out[m], word[m]);
                chk("ser_out",    m, 8'(ser_out[m]), 8'(word[m][sel_m[m]]));
                chk("done",       m, 8'(done[m]), 8'(done_m[m]));
                chk("busy",       m, 8'(busy[m]), 8'(active[m] || gapleft[m] > 0));
            end
            rdy[m] = m_ready(m);
        end
        if (ser_valid[0] === 1'b1 && ser_ready) rx0 = {rx0[6:0], ser_out[0]};
        if (ser_valid[1] === 1'b1 && ser_ready) rx1 = {ser_out[1], rx1[7:1]};
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                active[m] = 0; beat[m] = 0; gapleft[m] = 0;
                word[m] = 8'h00; done_m[m] = 0; sel_m[m] = 0;
            end else begin
                done_m[m] = 0;
                if (active[m] && ser_ready) begin
                    if (beat[m] == 7) begin
                        done_m[m]  = 1;
                        active[m]  = 0;
                        gapleft[m] = gap_cfg[m];
                    end else begin
                        beat[m]++;
                    end
                end else if (!active[m] && gapleft[m] > 0) begin
                    gapleft[m]--;
                end
                if (load_valid && rdy[m]) begin
                    word[m] = data_in; active[m] = 1; beat[m] = 0;
                end
                if (active[m]) sel_m[m] = msb_cfg[m] ? 7 - beat[m] : beat[m];
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; data_in = 8'h00; ser_ready = 1'b0;
        rx0 = 8'h00; rx1 = 8'h00;
        cycle(0);
        cycle(0);
        rst = 1'b0;
        repeat (2) cycle(1);

        // MSB-first / LSB-first streaming of A5 with no stalls
        rx0 = 8'h00; rx1 = 8'h00;
        data_in = 8'hA5; load_valid = 1'b1; ser_ready = 1'b1;
        cycle(1);
        load_valid = 1'b0; data_in = 8'h5A;
        repeat (14) cycle(1);
        chk("rx_a5", 0, rx0, 8'hA5);
        chk("rx_a5", 1, rx1, 8'hA5);

        // stalls on every other cycle
        rx0 = 8'h00; rx1 = 8'h00;
        data_in = 8'h3C; load_valid = 1'b1; ser_ready = 1'b1;
        cycle(1);
        load_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ser_ready = (i % 2 == 0);
            cycle(1);
        end
        chk("rx_3c", 0, rx0, 8'h3C);
        chk("rx_3c", 1, rx1, 8'h3C);
        ser_ready = 1'b1;
        repeat (5) cycle(1);

        // LOAD_VALID held high: back-to-back on gap-0, gap enforced on gap-3
        load_valid = 1'b1; data_in = 8'hFF;
        repeat (9) cycle(1);
        data_in = 8'h00;
        repeat (12) cycle(1);
        load_valid = 1'b0;
        repeat (6) cycle(1);

        // reset at the 4th beat aborts the word
        data_in = 8'h81; load_valid = 1'b1;
        cycle(1);
        load_valid = 1'b0;
        repeat (3) cycle(1);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        repeat (2) cycle(1);
        rx0 = 8'h00; rx1 = 8'h00;
        data_in = 8'h01; load_valid = 1'b1;
        cycle(1);
        load_valid = 1'b0;
        repeat (12) cycle(1);
        chk("rx_01", 0, rx0, 8'h01);
        chk("rx_01", 1, rx1, 8'h01);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            load_valid = $urandom_range(0, 1) != 0;
            data_in    = 8'($urandom);
            ser_ready  = ($urandom_range(0, 3) != 0);
            cycle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
